// File: rtl/logic_seq_pkg.sv
// Shared constants and state encoding for the logic-op sequencer slice.
package logic_seq_pkg;

   localparam int unsigned REG_SEL_W = 4;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;

   typedef enum logic [2:0] {
      IDLE,
      TY,
      TZ,
      TWB,
      FIN
   } state_t;

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Request and bus-control bundle between the control unit and the sequencer.
interface logic_op_sequencer_if
   import logic_seq_pkg::*;
#(
   parameter int unsigned REG_SEL_W = logic_seq_pkg::REG_SEL_W
);
   logic                 start;
   logic [2:0]           op;
   logic [REG_SEL_W-1:0] ra;
   logic [REG_SEL_W-1:0] rb;
   logic [REG_SEL_W-1:0] rc;

   logic                 reg_out_en;
   logic [REG_SEL_W-1:0] reg_out_sel;
   logic                 reg_in_en;
   logic [REG_SEL_W-1:0] reg_in_sel;
   logic                 y_in;
   logic                 z_in;
   logic                 z_lo_out;
   logic [2:0]           alu_op;
   logic                 busy;
   logic                 done;
   logic                 err;

   modport master (
      output start, op, ra, rb, rc,
      input  reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
      input  y_in, z_in, z_lo_out, alu_op, busy, done, err
   );

   modport slave (
      input  start, op, ra, rb, rc,
      output reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
      output y_in, z_in, z_lo_out, alu_op, busy, done, err
   );

endinterface

// File: rtl/logic_seq_decode.sv
// Classifies a logic opcode as legal and/or unary (NOT).
module logic_seq_decode
   import logic_seq_pkg::*;
(
   input  logic [2:0] op,
   output logic       is_legal,
   output logic       is_unary
);

   always_comb begin
      is_legal = 1'b0;
      is_unary = 1'b0;
      case (op)
         OP_AND, OP_OR, OP_XOR: is_legal = 1'b1;
         OP_NOT: begin
            is_legal = 1'b1;
            is_unary = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/logic_op_sequencer.sv
// T-step sequencer for AND/OR/XOR/NOT over the shared bus.
// Optional LOGIC_SEQ_STALL_EN adds a stall input that freezes TY/TZ/TWB.
module logic_op_sequencer
   import logic_seq_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
`ifdef LOGIC_SEQ_STALL_EN
   input  logic                   stall,
`endif
   logic_op_sequencer_if.slave    seq
);

   state_t                 state;
   logic [2:0]             op_q;
   logic [REG_SEL_W-1:0]   ra_q;
   logic [REG_SEL_W-1:0]   rc_q;

   logic                   reg_out_en_r;
   logic [REG_SEL_W-1:0]   reg_out_sel_r;
   logic                   reg_in_en_r;
   logic [REG_SEL_W-1:0]   reg_in_sel_r;
   logic                   y_in_r;
   logic                   z_in_r;
   logic                   z_lo_out_r;
   logic [2:0]             alu_op_r;
   logic                   busy_r;
   logic                   done_r;
   logic                   err_r;

   logic                   is_legal;
   logic                   is_unary;
   logic                   hold;

   logic_seq_decode u_decode (
      .op       (seq.op),
      .is_legal (is_legal),
      .is_unary (is_unary)
   );

`ifdef LOGIC_SEQ_STALL_EN
   assign hold = stall && (state inside {TY, TZ, TWB});
`else
   assign hold = 1'b0;
`endif

   // Outputs are computed for the state being entered, so each T-step's
   // controls are visible for exactly the cycle that state is occupied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         op_q          <= '0;
         ra_q          <= '0;
         rc_q          <= '0;
         reg_out_en_r  <= 1'b0;
         reg_out_sel_r <= '0;
         reg_in_en_r   <= 1'b0;
         reg_in_sel_r  <= '0;
         y_in_r        <= 1'b0;
         z_in_r        <= 1'b0;
         z_lo_out_r    <= 1'b0;
         alu_op_r      <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
      end else if (!hold) begin
         reg_out_en_r  <= 1'b0;
         reg_out_sel_r <= '0;
         reg_in_en_r   <= 1'b0;
         reg_in_sel_r  <= '0;
         y_in_r        <= 1'b0;
         z_in_r        <= 1'b0;
         z_lo_out_r    <= 1'b0;
         alu_op_r      <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
         case (state)
            IDLE: begin
               if (seq.start) begin
                  op_q   <= seq.op;
                  ra_q   <= seq.ra;
                  rc_q   <= seq.rc;
                  busy_r <= 1'b1;
                  if (!is_legal) begin
                     state  <= FIN;
                     done_r <= 1'b1;
                     err_r  <= 1'b1;
                  end else if (is_unary) begin
                     // NOT skips Y: the single source goes straight to the logic unit.
                     state         <= TZ;
                     reg_out_en_r  <= 1'b1;
                     reg_out_sel_r <= seq.rb;
                     z_in_r        <= 1'b1;
                     alu_op_r      <= seq.op;
                  end else begin
                     state         <= TY;
                     reg_out_en_r  <= 1'b1;
                     reg_out_sel_r <= seq.rb;
                     y_in_r        <= 1'b1;
                  end
               end
            end
            TY: begin
               state         <= TZ;
               busy_r        <= 1'b1;
               reg_out_en_r  <= 1'b1;
               reg_out_sel_r <= rc_q;
               z_in_r        <= 1'b1;
               alu_op_r      <= op_q;
            end
            TZ: begin
               state        <= TWB;
               busy_r       <= 1'b1;
               z_lo_out_r   <= 1'b1;
               reg_in_en_r  <= 1'b1;
               reg_in_sel_r <= ra_q;
            end
            TWB: begin
               state  <= FIN;
               busy_r <= 1'b1;
               done_r <= 1'b1;
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign seq.reg_out_en  = reg_out_en_r;
   assign seq.reg_out_sel = reg_out_sel_r;
   assign seq.reg_in_en   = reg_in_en_r;
   assign seq.reg_in_sel  = reg_in_sel_r;
   assign seq.y_in        = y_in_r;
   assign seq.z_in        = z_in_r;
   assign seq.z_lo_out    = z_lo_out_r;
   assign seq.alu_op      = alu_op_r;
   assign seq.busy        = busy_r;
   assign seq.done        = done_r;
   assign seq.err         = err_r;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Scoreboard bench for logic_op_sequencer with a bus/Y/Z/register-file model.
module tb_logic_op_sequencer;

   typedef logic [18:0] ctl_t;
   typedef struct {
      logic [3:0]  idx;
      logic [31:0] val;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
`ifdef LOGIC_SEQ_STALL_EN
   logic stall = 1'b0;
`endif

   logic_op_sequencer_if #(.REG_SEL_W(4)) sif ();

   logic_op_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef LOGIC_SEQ_STALL_EN
      .stall (stall),
`endif
      .seq   (sif.slave)
   );

   always #5 clk = ~clk;

   int   checks    = 0;
   int   passed    = 0;
   int   done_cnt  = 0;
   int   conflicts = 0;
   ctl_t exp_q[$];
   res_t res_q[$];

   logic [31:0] rf [16];
   logic [31:0] y_r = '0;
   logic [31:0] z_r = '0;
   logic [31:0] bus_v;

   // Datapath model driven purely by the sequencer's controls.
   always @(posedge clk) begin
      bus_v = sif.reg_out_en ? rf[sif.reg_out_sel] : z_r;
      if (sif.reg_out_en && sif.z_lo_out) conflicts++;
      if (sif.done) done_cnt++;
      if (sif.y_in) y_r <= bus_v;
      if (sif.z_in) begin
         case (sif.alu_op)
            3'b000:  z_r <= y_r & bus_v;
            3'b001:  z_r <= y_r | bus_v;
            3'b010:  z_r <= y_r ^ bus_v;
            default: z_r <= ~bus_v;
         endcase
      end
      if (sif.reg_in_en) rf[sif.reg_in_sel] <= bus_v;
   end

   function automatic ctl_t mk(input int b, input int d, input int e, input int roe,
                               input int ros, input int rie, input int ris,
                               input int y, input int z, input int zl, input int alu);
      return {1'(b), 1'(d), 1'(e), 1'(roe), 4'(ros), 1'(rie), 4'(ris),
              1'(y), 1'(z), 1'(zl), 3'(alu)};
   endfunction

   function automatic ctl_t ctl_now();
      return {sif.busy, sif.done, sif.err, sif.reg_out_en, sif.reg_out_sel,
              sif.reg_in_en, sif.reg_in_sel, sif.y_in, sif.z_in, sif.z_lo_out, sif.alu_op};
   endfunction

   task automatic start_op(input logic [2:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rc);
      sif.start = 1'b1;
      sif.op    = op;
      sif.ra    = ra;
      sif.rb    = rb;
      sif.rc    = rc;
   endtask

   task automatic test_reset();
      ctl_t got;
      sif.start = 1'b0;
      sif.op = '0; sif.ra = '0; sif.rb = '0; sif.rc = '0;
      for (int i = 0; i < 16; i++) rf[i] = 32'h0;
      rf[1] = 32'hAAAA_AAAA; rf[2] = 32'h5555_5555; rf[4] = 32'h0000_0037;
      rf[6] = 32'hFFFF_FFFF; rf[7] = 32'hABCD_1234; rf[10] = 32'h1234_5678;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      got = ctl_now();
      checks++;
      if (got !== '0) $display("FAIL reset_outputs: got %h expected %h", got, ctl_t'(0));
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_or();
      ctl_t got, ev;
      res_t r;
      exp_q.push_back(mk(1,0,0,1,1,0,0,1,0,0,0));
      exp_q.push_back(mk(1,0,0,1,2,0,0,0,1,0,1));
      exp_q.push_back(mk(1,0,0,0,0,1,3,0,0,1,0));
      exp_q.push_back(mk(1,1,0,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
      res_q.push_back('{idx: 4'd3, val: 32'hFFFF_FFFF});
      start_op(logic_seq_pkg::OP_OR, 4'd3, 4'd1, 4'd2);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         got = ctl_now();
         ev  = exp_q.pop_front();
         checks++;
         if (got !== ev) $display("FAIL or_ctl c%0d: got %h expected %h", k, got, ev);
         else passed++;
         if (k == 1) sif.start = 1'b0;
         if (sif.done) begin
            r = res_q.pop_front();
            checks++;
            if (rf[r.idx] !== r.val) $display("FAIL or_result R%0d: got %h expected %h", r.idx, rf[r.idx], r.val);
            else passed++;
         end
      end
   endtask

   task automatic test_not();
      ctl_t got, ev;
      res_t r;
      exp_q.push_back(mk(1,0,0,1,4,0,0,0,1,0,3));
      exp_q.push_back(mk(1,0,0,0,0,1,5,0,0,1,0));
      exp_q.push_back(mk(1,1,0,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
      res_q.push_back('{idx: 4'd5, val: 32'hFFFF_FFC8});
      start_op(logic_seq_pkg::OP_NOT, 4'd5, 4'd4, 4'd9);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         got = ctl_now();
         ev  = exp_q.pop_front();
         checks++;
         if (got !== ev) $display("FAIL not_ctl c%0d: got %h expected %h", k, got, ev);
         else passed++;
         if (k == 1) sif.start = 1'b0;
         if (sif.done) begin
            r = res_q.pop_front();
            checks++;
            if (rf[r.idx] !== r.val) $display("FAIL not_result R%0d: got %h expected %h", r.idx, rf[r.idx], r.val);
            else passed++;
         end
      end
   endtask

   task automatic test_illegal();
      ctl_t got, ev;
      exp_q.push_back(mk(1,1,1,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
      start_op(3'b110, 4'd12, 4'd1, 4'd2);
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         got = ctl_now();
         ev  = exp_q.pop_front();
         checks++;
         if (got !== ev) $display("FAIL illegal_ctl c%0d: got %h expected %h", k, got, ev);
         else passed++;
         if (k == 1) sif.start = 1'b0;
      end
      checks++;
      if (rf[12] !== 32'h0) $display("FAIL illegal_no_write: got %h expected %h", rf[12], 32'h0);
      else passed++;
   endtask

   task automatic test_back_to_back();
      ctl_t got, ev;
      res_t r;
      int   d0;
      d0 = done_cnt;
      exp_q.push_back(mk(1,0,0,1,6,0,0,1,0,0,0));
      exp_q.push_back(mk(1,0,0,1,7,0,0,0,1,0,0));
      exp_q.push_back(mk(1,0,0,0,0,1,8,0,0,1,0));
      exp_q.push_back(mk(1,1,0,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(1,0,0,1,6,0,0,1,0,0,0));
      exp_q.push_back(mk(1,0,0,1,7,0,0,0,1,0,2));
      exp_q.push_back(mk(1,0,0,0,0,1,9,0,0,1,0));
      exp_q.push_back(mk(1,1,0,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
      res_q.push_back('{idx: 4'd8, val: 32'hABCD_1234});
      res_q.push_back('{idx: 4'd9, val: 32'h5432_EDCB});
      start_op(logic_seq_pkg::OP_AND, 4'd8, 4'd6, 4'd7);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         got = ctl_now();
         ev  = exp_q.pop_front();
         checks++;
         if (got !== ev) $display("FAIL b2b_ctl c%0d: got %h expected %h", k, got, ev);
         else passed++;
         if (sif.done) begin
            r = res_q.pop_front();
            checks++;
            if (rf[r.idx] !== r.val) $display("FAIL b2b_result R%0d: got %h expected %h", r.idx, rf[r.idx], r.val);
            else passed++;
         end
         if (k == 5) begin
            checks++;
            if (done_cnt - d0 !== 1) $display("FAIL b2b_single_done: got %0d expected %0d", done_cnt - d0, 1);
            else passed++;
         end
         // start stays high; operands change mid-operation and feed the second op
         if (k == 1) start_op(logic_seq_pkg::OP_XOR, 4'd9, 4'd6, 4'd7);
         if (k == 6) sif.start = 1'b0;
      end
      checks++;
      if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d expected %0d", done_cnt - d0, 2);
      else passed++;
   endtask

   task automatic test_reset_mid();
      ctl_t got;
      int   d0;
      start_op(logic_seq_pkg::OP_AND, 4'd10, 4'd6, 4'd7);
      @(negedge clk);
      sif.start = 1'b0;
      @(negedge clk);
      got = ctl_now();
      checks++;
      if (got !== mk(1,0,0,1,7,0,0,0,1,0,0)) $display("FAIL rst_mid_in_tz: got %h expected %h", got, mk(1,0,0,1,7,0,0,0,1,0,0));
      else passed++;
      d0 = done_cnt;
      #1 rst_n = 1'b0;
      #1 got = ctl_now();
      checks++;
      if (got !== '0) $display("FAIL rst_mid_async: got %h expected %h", got, ctl_t'(0));
      else passed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (done_cnt !== d0) $display("FAIL rst_mid_no_done: got %0d expected %0d", done_cnt, d0);
      else passed++;
      checks++;
      if (rf[10] !== 32'h1234_5678) $display("FAIL rst_mid_dest: got %h expected %h", rf[10], 32'h1234_5678);
      else passed++;
   endtask

`ifdef LOGIC_SEQ_STALL_EN
   task automatic test_stall();
      ctl_t got, ev;
      res_t r;
      exp_q.push_back(mk(1,0,0,1,6,0,0,1,0,0,0));
      exp_q.push_back(mk(1,0,0,1,6,0,0,1,0,0,0));
      exp_q.push_back(mk(1,0,0,1,6,0,0,1,0,0,0));
      exp_q.push_back(mk(1,0,0,1,7,0,0,0,1,0,2));
      exp_q.push_back(mk(1,0,0,0,0,1,11,0,0,1,0));
      exp_q.push_back(mk(1,1,0,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
      res_q.push_back('{idx: 4'd11, val: 32'h5432_EDCB});
      start_op(logic_seq_pkg::OP_XOR, 4'd11, 4'd6, 4'd7);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         got = ctl_now();
         ev  = exp_q.pop_front();
         checks++;
         if (got !== ev) $display("FAIL stall_ctl c%0d: got %h expected %h", k, got, ev);
         else passed++;
         if (sif.done) begin
            r = res_q.pop_front();
            checks++;
            if (rf[r.idx] !== r.val) $display("FAIL stall_result R%0d: got %h expected %h", r.idx, rf[r.idx], r.val);
            else passed++;
         end
         if (k == 1) begin
            sif.start = 1'b0;
            stall = 1'b1;
         end
         if (k == 3) stall = 1'b0;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_or();
      test_not();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
`ifdef LOGIC_SEQ_STALL_EN
      test_stall();
`endif
      checks++;
      if (conflicts !== 0) $display("FAIL bus_single_driver: got %0d expected %0d", conflicts, 0);
      else passed++;
      checks++;
      if (exp_q.size() + res_q.size() !== 0) $display("FAIL scoreboard_drained: got %0d expected %0d", exp_q.size() + res_q.size(), 0);
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/logic_op_sequencer.md
# logic_op_sequencer

Multi-cycle control sequencer that runs one register-to-register bitwise logic instruction (AND, OR, XOR, NOT) over the single shared CPU bus. It accepts a decoded request from the control unit and drives register-file, Y, Z and logic-unit controls in fixed T-steps. It then signals completion. It sits between the instruction decode/control FSM and the bus datapath (register file, Y register, logic units, Z register).

## Interface
- REG_SEL_W, 4: width of a register index (16 general registers).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  3  000 AND, 001 OR, 010 XOR, 011 NOT; 1xx illegal.
- ra  in  REG_SEL_W  destination register index.
- rb  in  REG_SEL_W  first source, or the only source for NOT.
- rc  in  REG_SEL_W  second source; ignored for NOT.
- reg_out_en  out  1  selected register drives the bus.
- reg_out_sel  out  REG_SEL_W  register driving the bus.
- reg_in_en  out  1  selected register loads from the bus.
- reg_in_sel  out  REG_SEL_W  register loading from the bus.
- y_in  out  1  load Y from the bus.
- z_in  out  1  load Z from the logic-unit output.
- z_lo_out  out  1  Z low word drives the bus.
- alu_op  out  3  logic-unit select; valid while z_in=1.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-op pulse, coincident with done.

## Operation
- States: IDLE, TY, TZ, TWB, FIN.
- All outputs are registered, Moore-style from state plus latched operands.
- IDLE with start=1:
  - Latch op, ra, rb and rc.
  - Legal binary op: go to TY.
  - NOT: go to TZ.
  - Illegal op: go to FIN with err flagged.
- TY: reg_out_en=1, reg_out_sel=rb, y_in=1. Go to TZ.
- TZ:
  - Binary op: reg_out_sel=rc.
  - NOT: reg_out_sel=rb.
  - In both cases reg_out_en=1, z_in=1, alu_op=op. Go to TWB.
- TWB: z_lo_out=1, reg_in_en=1, reg_in_sel=ra. Go to FIN.
- FIN: done=1, err=1 only for an illegal op. Go to IDLE.
- busy=1 in every state except IDLE.
- start while busy=1 is ignored and not queued.
- Operand changes after acceptance have no effect.
- ra equal to rb or rc is legal; the write-back occurs after the final read.
- Illegal op: no bus, Y, Z or register control is asserted at any point.
- At most one bus driver per cycle (reg_out_en and z_lo_out are never both 1).

## Timing
- Acceptance edge = cycle 0.
- Binary op: TY in cycle 1, TZ in cycle 2, TWB in cycle 3, done in cycle 4.
- NOT: TZ in cycle 1, TWB in cycle 2, done in cycle 3.
- Illegal op: done and err in cycle 1.
- IDLE is re-entered the cycle after FIN. A new start is accepted no earlier than that cycle, giving a back-to-back throughput of 5 cycles per binary op.
- Reset value of every output is 0, including all select fields; state is IDLE.
- rst_n low mid-operation returns the block to IDLE immediately (asynchronously).
  - All controls drop without waiting for a clock edge.
  - The partial operation is abandoned and no done is issued.

## Configuration
- LOGIC_SEQ_STALL_EN defined:
  - Adds input port stall (1 bit).
  - While stall=1 in TY, TZ or TWB, the state and all outputs hold.
  - stall is ignored in IDLE and FIN.
  - Latency grows by one cycle per stalled cycle.
- LOGIC_SEQ_STALL_EN undefined: no stall port; latency is fixed as stated above.

## Structure
- Package logic_seq_pkg holds:
  - Opcode constants OP_AND, OP_OR, OP_XOR, OP_NOT.
  - The state enum (IDLE, TY, TZ, TWB, FIN).
  - The default REG_SEL_W.
- Sub-module logic_seq_decode:
  - Combinational classifier of op into is_legal and is_unary.
  - Used once at acceptance.

## Test plan
- OR, rb=1 (0xAAAAAAAA), rc=2 (0x55555555), ra=3, with a bench datapath model:
  - TY/TZ/TWB appear in cycles 1/2/3, done in cycle 4.
  - R3 = 0xFFFFFFFF.
- NOT, rb=4 (0x00000037), ra=5:
  - No y_in at any point; done in cycle 3.
  - R5 = 0xFFFFFFC8.
- op=110:
  - done and err high in cycle 1.
  - No other control asserted; busy high for cycle 1 only.
- Start pulses held high during an AND (rb=6 0xFFFFFFFF, rc=7 0xABCD1234, ra=8):
  - Exactly one completion; R8 = 0xABCD1234.
  - The next start is accepted in cycle 5.
- rst_n asserted low during TZ:
  - All outputs 0 before the next edge.
  - No done; the destination register is unchanged.
- With LOGIC_SEQ_STALL_EN: stall=1 for 2 cycles in TY:
  - TY is held for 3 cycles total.
  - done arrives in cycle 6 with a correct result.
